// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so a second byte
// can queue behind the frame in flight and follow it with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RESET,
  uart_tx_if.slave   bus,
  output logic       TXD,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shifter, shifter_nxt;
  logic [7:0]  hold, hold_nxt;
  logic        hold_full, hold_full_nxt;
  logic        ready;
  logic        txd_nxt, busy_nxt, ready_nxt;
  logic        accept, bit_end;

  assign accept       = bus.tx_valid & ready;
  assign bit_end      = (cnt == LAST);
  assign bus.tx_ready = ready;

  // State and datapath registers; outputs are registered from their next values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b0;
      TXD       <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shifter   <= shifter_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      ready     <= ready_nxt;
      TXD       <= txd_nxt;
      busy      <= busy_nxt;
    end
  end

  // Frame sequencing, bit timing and holding-register bookkeeping.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = bit_end ? 16'd0 : 16'(cnt + 16'd1);
    idx_nxt       = idx;
    shifter_nxt   = shifter;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          state_nxt   = START;
          shifter_nxt = bus.tx_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shifter_nxt = shifter >> 1;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (hold_full) begin
            state_nxt     = START;
            shifter_nxt   = hold;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            // Byte arriving exactly at the stop boundary goes straight out.
            state_nxt   = START;
            shifter_nxt = bus.tx_data;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Mid-frame acceptance parks the byte; tx_ready keeps this from overwriting.
    if (accept && state != IDLE && !(state == STOP && bit_end)) begin
      hold_full_nxt = 1'b1;
      hold_nxt      = bus.tx_data;
    end
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shifter_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
    busy_nxt  = (state_nxt != IDLE) || hold_full_nxt;
    ready_nxt = !hold_full_nxt;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame table plus hand-written back-to-back,
// backpressure and mid-frame reset sequences.
module tb_uart_tx;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic txd1, busy1, txd2, busy2;
  int   checks = 0;
  int   errors = 0;

  uart_tx_if bus1();
  uart_tx_if bus2();

  uart_tx #(.CLKS_PER_BIT(4)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1), .TXD(txd1), .busy(busy1));
  uart_tx #(.CLKS_PER_BIT(2)) dut2 (.CLK(CLK), .RESET(RESET), .bus(bus2), .TXD(txd2), .busy(busy2));

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sel;    // 0: divider 4, 1: divider 2
    logic [7:0] data;
    logic [9:0] frame;  // frame[i] = TXD level in bit slot i (start first)
    int         cpb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input vec_t v);
    @(negedge CLK);
    chk("ready_before", v.sel ? bus2.tx_ready : bus1.tx_ready, 1);
    if (v.sel) begin bus2.tx_valid = 1'b1; bus2.tx_data = v.data; end
    else       begin bus1.tx_valid = 1'b1; bus1.tx_data = v.data; end
    @(posedge CLK);
    #1;
    bus1.tx_valid = 1'b0; bus2.tx_valid = 1'b0;
    bus1.tx_data = ~v.data; bus2.tx_data = ~v.data;
    for (int k = 0; k < 10 * v.cpb; k++) begin
      @(negedge CLK);
      chk("frame_txd", v.sel ? txd2 : txd1, {31'd0, v.frame[k / v.cpb]});
      chk("frame_busy", v.sel ? busy2 : busy1, 1);
      chk("frame_ready", v.sel ? bus2.tx_ready : bus1.tx_ready, 1);
    end
    @(negedge CLK);
    chk("end_txd", v.sel ? txd2 : txd1, 1);
    chk("end_busy", v.sel ? busy2 : busy1, 0);
  endtask

  initial begin
    logic [9:0] f1, f2, f3;
    logic       exp_ready;
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00;
    bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00;

    vecs[0] = '{1'b0, 8'h55, 10'h2AA, 4};
    vecs[1] = '{1'b0, 8'h00, 10'h200, 4};
    vecs[2] = '{1'b0, 8'hFF, 10'h3FE, 4};
    vecs[3] = '{1'b0, 8'h01, 10'h202, 4};
    vecs[4] = '{1'b1, 8'h80, 10'h300, 2};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_txd", txd1, 1);
    chk("rst_ready", bus1.tx_ready, 0);
    chk("rst_busy", busy1, 0);
    RESET = 1'b0;
    #1 chk("ready_before_edge", bus1.tx_ready, 0);
    @(negedge CLK);
    chk("ready_first_edge", bus1.tx_ready, 1);
    chk("ready_first_edge2", bus2.tx_ready, 1);

    // Idle for 100 cycles
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      chk("idle_txd", txd1, 1);
      chk("idle_ready", bus1.tx_ready, 1);
      chk("idle_busy", busy1, 0);
    end

    // Single frames, including the minimum divider
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Back-to-back with backpressure: 0xA5, 0x3C five cycles later, then 0xFF
    f1 = 10'h34A; f2 = 10'h278; f3 = 10'h3FE;
    @(negedge CLK);
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'hA5;
    @(posedge CLK);
    #1 bus1.tx_valid = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge CLK);
      if (k < 40)      chk("b2b_txd1", txd1, {31'd0, f1[k / 4]});
      else if (k < 80) chk("b2b_txd2", txd1, {31'd0, f2[(k - 40) / 4]});
      else             chk("b2b_txd3", txd1, {31'd0, f3[(k - 80) / 4]});
      exp_ready = !((k >= 5 && k < 40) || (k >= 41 && k < 80));
      chk("b2b_ready", bus1.tx_ready, {31'd0, exp_ready});
      chk("b2b_busy", busy1, 1);
      if (k == 4) begin
        bus1.tx_valid = 1'b1; bus1.tx_data = 8'h3C;
      end else if (k >= 5 && k <= 40) begin
        bus1.tx_valid = 1'b1;
        bus1.tx_data  = bus1.tx_ready ? 8'hFF : (k[0] ? 8'h00 : 8'h5A);
      end else begin
        bus1.tx_valid = 1'b0;
      end
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      chk("b2b_after_txd", txd1, 1);
      chk("b2b_after_busy", busy1, 0);
    end

    // Mid-frame reset during data bit 3 of 0x00 with 0x11 held
    @(negedge CLK);
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'h00;
    @(posedge CLK);
    #1 bus1.tx_data = 8'h11;
    @(posedge CLK);
    #1 bus1.tx_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLK);
      if (k == 1) chk("mr_held_ready", bus1.tx_ready, 0);
      chk("mr_txd_pre", txd1, 0);
    end
    RESET = 1'b1;
    #1;
    chk("mr_rst_txd", txd1, 1);
    chk("mr_rst_ready", bus1.tx_ready, 0);
    chk("mr_rst_busy", busy1, 0);
    @(negedge CLK);
    chk("mr_rst_txd2", txd1, 1);
    RESET = 1'b0;
    #1 chk("mr_rel_ready", bus1.tx_ready, 0);
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      chk("mr_post_txd", txd1, 1);
      chk("mr_post_busy", busy1, 0);
      chk("mr_post_ready", bus1.tx_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, default 104, CLK cycles per serial bit period (legal range 2..65535).
REQ-002 SHALL provide port: CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port: RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: tx_data  input  8  byte to transmit, sampled only at acceptance.
REQ-005 SHALL provide port: tx_valid  input  1  producer has a byte on tx_data.
REQ-006 SHALL provide port: tx_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL provide port: TXD  output  1  serial line, idle high, registered.
REQ-008 SHALL provide port: busy  output  1  frame in progress or byte pending.

Function
REQ-009 SHALL use the frame format 8N1: start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-010 SHALL hold every bit on TXD for exactly CLKS_PER_BIT cycles, timed by an internal bit counter counting 0..CLKS_PER_BIT-1 and cleared at each bit boundary.
REQ-011 SHALL define acceptance as a rising edge with tx_valid=1 and tx_ready=1; tx_data is captured only at acceptance, and changes while not accepted are ignored.
REQ-012 SHALL include a one-entry holding register; tx_ready SHALL be registered and equal to NOT(holding full).
REQ-013 SHALL sequence frames with state machine IDLE -> START -> DATA (8 bits, index 0..7) -> STOP -> IDLE, or STOP -> START when the holding register is full.
REQ-014 SHALL, on acceptance while in IDLE with the holding register empty, load the byte directly into the shifter and drive TXD=0 from that same edge, holding register staying empty.
REQ-015 SHALL, on acceptance while a frame is in progress, store the byte in the holding register and drop tx_ready on that edge.
REQ-016 SHALL, at the edge ending the stop-bit period with the holding register full, move the held byte into the shifter, enter START (TXD=0 from that edge, zero idle cycles between frames), and raise tx_ready on that edge.
REQ-017 SHALL prevent refilling in the same edge as a holding-to-shifter transfer, since tx_ready is 0 during that cycle.
REQ-018 SHALL return to IDLE with TXD=1 at the edge ending the stop-bit period when the holding register is empty.
REQ-019 SHALL drive busy=1 whenever state != IDLE or the holding register is full, registered and updated on the same edges as the state.
REQ-020 SHALL never generate glitches on TXD, which changes only on CLK edges or asynchronously on RESET.

Reset
REQ-021 SHALL, while RESET=1, force TXD=1, tx_ready=0, busy=0, state IDLE, bit counter 0 and holding register empty.
REQ-022 SHALL raise tx_ready to 1 at the first rising CLK edge after RESET deasserts.
REQ-023 SHALL, on RESET asserted mid-frame, abort the frame immediately with TXD=1 and discard any held byte; no partial frame resumes after reset.

Verification (CLKS_PER_BIT=4)
REQ-024 SHALL verify idle: after reset release -> TXD=1, tx_ready=1, busy=0 held for 100 cycles with tx_valid=0.
REQ-025 SHALL verify single byte: accept 0x55 in IDLE -> TXD=0,1,0,1,0,1,0,1,0,1, each level 4 cycles, 40 cycles total, then TXD=1 and busy=0 on the next edge.
REQ-026 SHALL verify back-to-back: accept 0xA5, then 0x3C 5 cycles later -> tx_ready=0 from the second acceptance until the edge ending the first stop bit; the second start bit begins on that edge; 80 contiguous frame cycles with no idle gap; bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
REQ-027 SHALL verify backpressure: tx_valid held high with a third byte 0xFF while tx_ready=0 and tx_data toggled -> only the value present at the acceptance edge is sent; exactly three frames emitted.
REQ-028 SHALL verify mid-frame reset: RESET pulsed during data bit 3 of 0x00 with a byte held -> TXD=1 during reset; no further 0 on TXD after release until a new acceptance; tx_ready=1 after first post-reset edge.
REQ-029 SHALL verify minimum divider: with CLKS_PER_BIT=2 send 0x80 -> 20-cycle frame, TXD=0 for 16 cycles (start plus bits 0..6), then 1 for 4 cycles.
